// File: rtl/ppu_pkg.sv
// ============================================================================
// Module   : ppu_pkg
// Brief    : Shared PPU types and constants (OAM DMA states, register map).
// Revision : 1.0
// ============================================================================
`default_nettype none

package ppu_pkg;

  localparam int          OAM_SIZE    = 256;
  localparam logic [2:0]  OAMADDR_REG = 3'd3;
  localparam logic [2:0]  OAMDATA_REG = 3'd4;
  localparam logic [15:0] OAMDMA_ADDR = 16'h4014;

  typedef enum logic [2:0] {
    D_IDLE  = 3'd0,
    D_ALIGN = 3'd1,
    D_READ  = 3'd2,
    D_LATCH = 3'd3,
    D_WRITE = 3'd4
  } dma_state_t;

endpackage

`default_nettype wire

// File: rtl/ppu_oam_dma_engine.sv
// ============================================================================
// Module   : ppu_oam_dma_engine
// Brief    : $4014 DMA sequencer; reads one CPU page, requests OAM writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ppu_oam_dma_engine
  import ppu_pkg::*;
#(
  parameter int DMA_LEN          = 256,
  parameter int DMA_ALIGN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_page,
  input  logic [7:0]  base_addr,
  input  logic        eval_busy,
  input  logic [7:0]  bus_data,
  output logic        busy,
  output logic        bus_rd,
  output logic [15:0] bus_addr,
  output logic        wr_req,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data
);

  // A zero-cycle alignment request is treated as a single cycle.
  localparam int             c_ALIGN_N    = (DMA_ALIGN_CYCLES > 1) ? DMA_ALIGN_CYCLES : 1;
  localparam int             c_AW         = (c_ALIGN_N > 1) ? $clog2(c_ALIGN_N) : 1;
  localparam logic [c_AW-1:0] c_ALIGN_LAST = c_AW'(c_ALIGN_N - 1);
  localparam logic [8:0]     c_LAST       = 9'(DMA_LEN - 1);

  dma_state_t      r_state, w_state_nxt;
  logic [8:0]      r_count, w_count_nxt;
  logic [c_AW-1:0] r_align, w_align_nxt;
  logic [7:0]      r_page;
  logic [7:0]      r_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= D_IDLE;
      r_count <= '0;
      r_align <= '0;
      r_page  <= '0;
      r_byte  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_align <= w_align_nxt;
      if (r_state == D_IDLE && start)
        r_page <= start_page;
      if (r_state == D_LATCH)
        r_byte <= bus_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_align_nxt = r_align;
    bus_rd      = 1'b0;
    wr_req      = 1'b0;
    case (r_state)
      D_IDLE: begin
        if (start) begin
          w_state_nxt = D_ALIGN;
          w_count_nxt = '0;
          w_align_nxt = '0;
        end
      end
      D_ALIGN: begin
        if (r_align == c_ALIGN_LAST)
          w_state_nxt = D_READ;
        else
          w_align_nxt = r_align + 1'b1;
      end
      D_READ: begin
        bus_rd      = 1'b1;
        w_state_nxt = D_LATCH;
      end
      D_LATCH: w_state_nxt = D_WRITE;
      D_WRITE: begin
        // The evaluator owns the RAM this cycle; hold the byte until it lets go.
        if (!eval_busy) begin
          wr_req      = 1'b1;
          w_count_nxt = r_count + 9'd1;
          w_state_nxt = (r_count == c_LAST) ? D_IDLE : D_READ;
        end
      end
      default: w_state_nxt = D_IDLE;
    endcase
  end

  assign busy     = (r_state != D_IDLE);
  assign bus_addr = {r_page, r_count[7:0]};
  assign wr_addr  = base_addr + r_count[7:0];
  assign wr_data  = r_byte;

endmodule

`default_nettype wire

// File: rtl/ppu_oam_arbiter.sv
// ============================================================================
// Module   : ppu_oam_arbiter
// Brief    : OAM owner; arbitrates evaluator, DMA and CPU $2003/$2004 access.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ppu_oam_arbiter
  import ppu_pkg::*;
#(
  parameter int DMA_LEN          = 256,
  parameter int DMA_ALIGN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        oamaddr_wr,
  input  logic        oamdata_wr,
  input  logic        dma_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  oam_addr,
  output logic        cpu_halt,
  output logic [15:0] dma_bus_addr,
  output logic        dma_bus_rd,
  input  logic [7:0]  dma_bus_data,
  input  logic        eval_busy,
  input  logic [7:0]  eval_addr,
  output logic [7:0]  eval_data,
  output logic [7:0]  spram_addr,
  output logic        spram_we,
  output logic [7:0]  spram_wdata,
  input  logic [7:0]  spram_rdata,
  output logic        oam_conflict
);

  logic [7:0] r_oam_addr;
  logic [7:0] r_cpu_rdata;
  logic       r_rd_slot;
  logic       r_conflict;

  logic       w_halt;
  logic       w_cpu_ok;
  logic       w_addr_ld;
  logic       w_data_req;
  logic       w_cpu_wr;
  logic       w_dma_start;
  logic       w_dma_wr_req;
  logic [7:0] w_dma_wr_addr;
  logic [7:0] w_dma_wr_data;
  logic       w_rd_slot;

  // The CPU is stalled during DMA, so its strobes are meaningless then.
  assign w_cpu_ok    = !w_halt;
  assign w_addr_ld   = oamaddr_wr && w_cpu_ok;
  assign w_data_req  = oamdata_wr && w_cpu_ok && !oamaddr_wr;
  assign w_cpu_wr    = w_data_req && !eval_busy && !w_dma_wr_req;
  assign w_dma_start = dma_wr && w_cpu_ok;

  ppu_oam_dma_engine #(
    .DMA_LEN          (DMA_LEN),
    .DMA_ALIGN_CYCLES (DMA_ALIGN_CYCLES)
  ) u_dma (
    .clk        (clk),
    .rst        (rst),
    .start      (w_dma_start),
    .start_page (cpu_wdata),
    .base_addr  (r_oam_addr),
    .eval_busy  (eval_busy),
    .bus_data   (dma_bus_data),
    .busy       (w_halt),
    .bus_rd     (dma_bus_rd),
    .bus_addr   (dma_bus_addr),
    .wr_req     (w_dma_wr_req),
    .wr_addr    (w_dma_wr_addr),
    .wr_data    (w_dma_wr_data)
  );

  always_comb begin
    spram_addr  = r_oam_addr;
    spram_we    = 1'b0;
    spram_wdata = 8'h00;
    w_rd_slot   = 1'b0;
    if (eval_busy) begin
      spram_addr = eval_addr;
    end else if (w_dma_wr_req) begin
      spram_addr  = w_dma_wr_addr;
      spram_we    = 1'b1;
      spram_wdata = w_dma_wr_data;
    end else if (w_cpu_wr) begin
      spram_we    = 1'b1;
      spram_wdata = cpu_wdata;
    end else begin
      w_rd_slot = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oam_addr  <= 8'h00;
      r_cpu_rdata <= 8'h00;
      r_rd_slot   <= 1'b0;
      r_conflict  <= 1'b0;
    end else begin
      if (w_addr_ld)
        r_oam_addr <= cpu_wdata;
      else if (w_data_req)
        r_oam_addr <= r_oam_addr + 8'd1;
      r_conflict <= w_data_req && eval_busy;
      r_rd_slot  <= w_rd_slot;
      if (r_rd_slot)
        r_cpu_rdata <= spram_rdata;
    end
  end

  assign cpu_halt     = w_halt;
  assign oam_addr     = r_oam_addr;
  assign cpu_rdata    = r_cpu_rdata;
  assign oam_conflict = r_conflict;
  assign eval_data    = spram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ppu_oam_arbiter.sv
// ============================================================================
// Module   : tb_ppu_oam_arbiter
// Brief    : Scoreboard bench for ppu_oam_arbiter with OAM RAM and bus models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ppu_oam_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        oamaddr_wr = 1'b0;
  logic        oamdata_wr = 1'b0;
  logic        dma_wr = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic [7:0]  oam_addr;
  logic        cpu_halt;
  logic [15:0] dma_bus_addr;
  logic        dma_bus_rd;
  logic [7:0]  dma_bus_data = 8'h00;
  logic        eval_busy = 1'b0;
  logic [7:0]  eval_addr = 8'h00;
  logic [7:0]  eval_data;
  logic [7:0]  spram_addr;
  logic        spram_we;
  logic [7:0]  spram_wdata;
  logic [7:0]  spram_rdata = 8'h00;
  logic        oam_conflict;

  int errors = 0;
  int checks = 0;
  int halt_cycles = 0;
  int conflict_cnt = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  mem [256];

  ppu_oam_arbiter #(.DMA_LEN(256), .DMA_ALIGN_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .oamaddr_wr(oamaddr_wr), .oamdata_wr(oamdata_wr),
    .dma_wr(dma_wr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .oam_addr(oam_addr), .cpu_halt(cpu_halt), .dma_bus_addr(dma_bus_addr),
    .dma_bus_rd(dma_bus_rd), .dma_bus_data(dma_bus_data), .eval_busy(eval_busy),
    .eval_addr(eval_addr), .eval_data(eval_data), .spram_addr(spram_addr),
    .spram_we(spram_we), .spram_wdata(spram_wdata), .spram_rdata(spram_rdata),
    .oam_conflict(oam_conflict)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  // Synchronous single-port OAM, read-before-write.
  always @(posedge clk) begin
    if (spram_we) mem[spram_addr] <= spram_wdata;
    spram_rdata <= mem[spram_addr];
  end

  function automatic logic [7:0] bus_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
  endfunction

  always @(posedge clk) if (dma_bus_rd) dma_bus_data <= bus_byte(dma_bus_addr);

  // Write monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (cpu_halt) halt_cycles++;
    if (oam_conflict) conflict_cnt++;
    if (spram_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ram_write unexpected: addr=%02h data=%02h", spram_addr, spram_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({spram_addr, spram_wdata} !== e) begin
          errors++;
          $display("FAIL ram_write: got addr=%02h data=%02h, want addr=%02h data=%02h",
                   spram_addr, spram_wdata, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_oamaddr(input logic [7:0] a);
    oamaddr_wr = 1'b1; cpu_wdata = a;
    tick();
    oamaddr_wr = 1'b0;
  endtask

  task automatic start_dma(input logic [7:0] page, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({base + 8'(i), bus_byte({page, 8'(i)})});
    halt_cycles = 0;
    dma_wr = 1'b1; cpu_wdata = page;
    tick();
    dma_wr = 1'b0;
  endtask

  task automatic wait_halt_low;
    int n;
    n = 0;
    while (cpu_halt && n < 2000) begin tick(); n++; end
    if (cpu_halt) begin
      errors++; checks++;
      $display("FAIL halt_timeout: cpu_halt still high after %0d cycles", n);
    end
  endtask

  task automatic wait_bus_rd(input logic [7:0] idx);
    int n;
    n = 0;
    while (!(dma_bus_rd && dma_bus_addr[7:0] == idx) && n < 2000) begin tick(); n++; end
    checks++;
    if (!(dma_bus_rd && dma_bus_addr[7:0] == idx)) begin
      errors++;
      $display("FAIL bus_rd_timeout: index %02h never read", idx);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({oam_addr, cpu_rdata, cpu_halt, dma_bus_rd, dma_bus_addr, spram_we,
         spram_wdata, spram_addr, oam_conflict} !== 53'd0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%02h rdata=%02h halt=%b rd=%b baddr=%04h we=%b wd=%02h sa=%02h cf=%b",
               oam_addr, cpu_rdata, cpu_halt, dma_bus_rd, dma_bus_addr, spram_we,
               spram_wdata, spram_addr, oam_conflict);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_cpu_port;
    logic [7:0] d [3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    set_oamaddr(8'hFE);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'hFE + 8'(i), d[i]});
      oamdata_wr = 1'b1; cpu_wdata = d[i];
      tick();
      oamdata_wr = 1'b0;
    end
    checks++;
    if (oam_addr !== 8'h01) begin
      errors++; $display("FAIL cpu_oam_addr: got %02h want 01", oam_addr);
    end
    set_oamaddr(8'hFF);
    tick(); tick();
    checks++;
    if (cpu_rdata !== 8'h22) begin
      errors++; $display("FAIL cpu_rdata: got %02h want 22", cpu_rdata);
    end
  endtask

  task automatic test_dma;
    set_oamaddr(8'h10);
    start_dma(8'h02, 8'h10, 256);
    wait_halt_low();
    checks++;
    if (halt_cycles != 769) begin
      errors++; $display("FAIL dma_halt_len: got %0d want 769", halt_cycles);
    end
    checks++;
    if (oam_addr !== 8'h10) begin
      errors++; $display("FAIL dma_oam_addr: got %02h want 10", oam_addr);
    end
    tick(); tick();
    checks++;
    if (cpu_rdata !== 8'h5A) begin
      errors++; $display("FAIL dma_rdata: got %02h want 5a", cpu_rdata);
    end
  endtask

  task automatic test_contention;
    start_dma(8'h02, 8'h10, 256);
    wait_bus_rd(8'h05);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      eval_busy = 1'b1; eval_addr = 8'hC0 + 8'(i);
      #1;
      checks++;
      if (spram_addr !== eval_addr || spram_we !== 1'b0) begin
        errors++;
        $display("FAIL eval_priority: addr=%02h we=%b want addr=%02h we=0",
                 spram_addr, spram_we, eval_addr);
      end
      tick();
    end
    eval_busy = 1'b0;
    wait_halt_low();
    checks++;
    if (halt_cycles != 779) begin
      errors++; $display("FAIL contention_halt_len: got %0d want 779", halt_cycles);
    end
  endtask

  task automatic test_dropped_write;
    int c0;
    set_oamaddr(8'h40);
    c0 = conflict_cnt;
    eval_busy = 1'b1; eval_addr = 8'h07;
    oamdata_wr = 1'b1; cpu_wdata = 8'hAA;
    tick();
    oamdata_wr = 1'b0;
    eval_busy = 1'b0;
    tick(); tick();
    checks++;
    if (conflict_cnt - c0 != 1) begin
      errors++; $display("FAIL conflict_pulse: got %0d pulses want 1", conflict_cnt - c0);
    end
    checks++;
    if (oam_addr !== 8'h41) begin
      errors++; $display("FAIL dropped_oam_addr: got %02h want 41", oam_addr);
    end
    checks++;
    if (mem[8'h40] !== 8'h6A) begin
      errors++; $display("FAIL dropped_ram: RAM[40]=%02h want 6a", mem[8'h40]);
    end
  endtask

  task automatic test_simultaneous;
    int c0;
    c0 = conflict_cnt;
    oamaddr_wr = 1'b1; oamdata_wr = 1'b1; cpu_wdata = 8'h80;
    tick();
    oamaddr_wr = 1'b0; oamdata_wr = 1'b0;
    tick();
    checks++;
    if (oam_addr !== 8'h80) begin
      errors++; $display("FAIL simul_oam_addr: got %02h want 80", oam_addr);
    end
    checks++;
    if (conflict_cnt != c0) begin
      errors++; $display("FAIL simul_conflict: got %0d pulses want 0", conflict_cnt - c0);
    end
  endtask

  task automatic test_reset_mid_dma;
    start_dma(8'h02, 8'h80, 100);
    wait_bus_rd(8'd100);
    rst = 1'b0;
    #1;
    checks++;
    if (cpu_halt !== 1'b0 || dma_bus_rd !== 1'b0 || spram_we !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: halt=%b rd=%b we=%b want 0 0 0", cpu_halt, dma_bus_rd, spram_we);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (exp_q.size() != 0 || oam_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_abort: pending=%0d oam_addr=%02h want 0 00", exp_q.size(), oam_addr);
    end
    start_dma(8'h03, 8'h00, 256);
    wait_bus_rd(8'h00);
    checks++;
    if (dma_bus_addr !== 16'h0300) begin
      errors++; $display("FAIL restart_addr: got %04h want 0300", dma_bus_addr);
    end
    wait_halt_low();
    checks++;
    if (halt_cycles != 769) begin
      errors++; $display("FAIL restart_halt_len: got %0d want 769", halt_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_port();
    test_dma();
    test_contention();
    test_dropped_write();
    test_simultaneous();
    test_reset_mid_dma();
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_writes: %0d expected writes never seen", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ppu_oam_arbiter.md
Name: ppu_oam_arbiter

Overview:
- Sole owner of the 256-byte single-port sprite RAM (OAM).
- Shares the RAM between three requesters: the per-scanline sprite evaluator (read-only), the $4014 OAM DMA engine, and the CPU OAMADDR ($2003) / OAMDATA ($2004) register port.
- Runs the DMA state machine, halting the CPU and copying one 256-byte CPU page into OAM.
- Supplies the evaluator's base sprite address.

Parameters:
- DMA_LEN, 256, number of bytes transferred per DMA (must be 256 for NES behaviour; smaller values are for simulation only).
- DMA_ALIGN_CYCLES, 1, dummy cycles between the dma_wr strobe and the first DMA read.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- oamaddr_wr  in  1  one-cycle strobe, CPU write to $2003.
- oamdata_wr  in  1  one-cycle strobe, CPU write to $2004.
- dma_wr  in  1  one-cycle strobe, CPU write to $4014.
- cpu_wdata  in  8  CPU write data (OAMADDR value, OAMDATA byte, or DMA page).
- cpu_rdata  out  8  registered $2004 read value (byte at OAMADDR).
- oam_addr  out  8  current OAMADDR; feeds the evaluator's base sprite address.
- cpu_halt  out  1  high while DMA owns the CPU bus.
- dma_bus_addr  out  16  DMA read address {page, byte index}.
- dma_bus_rd  out  1  DMA read strobe; data is valid on dma_bus_data the following cycle.
- dma_bus_data  in  8  CPU bus read data.
- eval_busy  in  1  evaluator active; it owns the RAM this cycle.
- eval_addr  in  8  evaluator read address.
- eval_data  out  8  RAM read data, routed straight through from spram_rdata.
- spram_addr  out  8  RAM address.
- spram_we  out  1  RAM write enable.
- spram_wdata  out  8  RAM write data.
- spram_rdata  in  8  RAM read data; synchronous RAM, one-cycle latency.
- oam_conflict  out  1  one-cycle pulse when a CPU OAMDATA write is dropped.

Behaviour:
- Reset values:
  - All outputs 0: oam_addr, cpu_rdata, cpu_halt, dma_bus_rd, dma_bus_addr, spram_we, spram_wdata, spram_addr, oam_conflict.
  - DMA FSM in D_IDLE; DMA counter 0.
  - Reset asserted mid-DMA aborts the transfer immediately; OAM contents are left partially written.
- RAM port priority, fixed per cycle:
  1. eval_busy: spram_addr=eval_addr, spram_we=0.
  2. DMA in D_WRITE: write the latched byte.
  3. CPU OAMDATA write.
  4. Idle read slot: spram_addr=oam_addr.
- cpu_rdata is loaded from spram_rdata one cycle after each idle read slot. Otherwise it holds its value.
- eval_data equals spram_rdata, so the evaluator sees one-cycle read latency regardless of arbitration.
- OAMADDR register:
  - oamaddr_wr loads oam_addr=cpu_wdata.
  - An accepted oamdata_wr writes cpu_wdata to RAM[oam_addr], then oam_addr+1 modulo 256 (0xFF wraps to 0x00).
  - oamaddr_wr and oamdata_wr in the same cycle: the address load wins and the data write is dropped (no oam_conflict).
  - oamdata_wr while eval_busy: no RAM write, oam_addr still increments, oam_conflict pulses.
  - oamaddr_wr, oamdata_wr and dma_wr are all ignored while cpu_halt=1.
- DMA FSM states: D_IDLE, D_ALIGN, D_READ, D_LATCH, D_WRITE.
  - D_IDLE: on dma_wr, latch page=cpu_wdata, set count=0, go to D_ALIGN. cpu_halt rises the next cycle.
  - D_ALIGN: stay DMA_ALIGN_CYCLES cycles, then go to D_READ.
  - D_READ: dma_bus_rd=1, dma_bus_addr={page,count[7:0]}, go to D_LATCH.
  - D_LATCH: capture dma_bus_data into the byte register, go to D_WRITE.
  - D_WRITE: if eval_busy, hold with no write. Otherwise write RAM[(oam_addr+count) mod 256] and increment count.
    - If count was DMA_LEN-1, go to D_IDLE and drop cpu_halt the same edge.
    - Otherwise go to D_READ.
- DMA timing:
  - Without eval contention: 3 cycles per byte; cpu_halt is high for DMA_ALIGN_CYCLES + 3*DMA_LEN cycles (769 by default).
  - Each eval_busy cycle during D_WRITE adds one cycle.
- oam_addr is unchanged by DMA.
- count is 9 bits wide; the RAM write index wraps at 8 bits.

Decomposition:
- Shared package ppu_pkg holds:
  - DMA state enum: D_IDLE..D_WRITE.
  - Constants: OAM_SIZE=256, OAMADDR_REG=3'd3, OAMDATA_REG=3'd4, OAMDMA_ADDR=16'h4014.
- One natural sub-module: ppu_oam_dma_engine. It contains the FSM, counter, page/byte registers and bus strobes, and exports a write request with its address and data. The arbiter top holds the priority mux and the OAMADDR register.

Test Plan:
- CPU port, no eval: oamaddr_wr 0xFE; oamdata_wr 0x11, 0x22, 0x33.
  - Required: RAM[FE]=11, RAM[FF]=22, RAM[00]=33; oam_addr=0x01.
- DMA, no eval: page 0x02 with bus memory[0x0200+i]=i^0x5A; oam_addr=0x10.
  - Required: cpu_halt high for exactly 769 cycles; RAM[(0x10+i)&0xFF]=i^0x5A for all i; oam_addr=0x10 after.
- DMA contention: eval_busy held high for 10 cycles during the D_WRITE of byte 5.
  - Required: halt extends to 779 cycles; data identical; spram_addr tracks eval_addr during those cycles with spram_we=0.
- Dropped CPU write: oamdata_wr 0xAA at oam_addr 0x40 while eval_busy.
  - Required: RAM[40] unchanged; oam_conflict pulses once; oam_addr=0x41.
- Simultaneous strobes: oamaddr_wr and oamdata_wr in the same cycle with cpu_wdata 0x80.
  - Required: oam_addr=0x80; no RAM write; no conflict pulse.
- Reset mid-DMA: assert rst at byte 100.
  - Required: cpu_halt=0 and dma_bus_rd=0 asynchronously; FSM in D_IDLE; a following dma_wr restarts from count 0.
